counter_updown_mod: RTL

//  Parametrised loadable up/down modulo counter. Generalises the team's basic

---
 rtl/counter_updown_mod.sv | 71 +++++++
 1 files changed

// File: rtl/counter_updown_mod.sv
// Loadable up/down modulo counter with programmable terminal value,
// wrap-or-saturate boundary handling, a wrap event pulse and a sticky overflow flag.
module counter_updown_mod #(
   parameter int WIDTH    = 5,
   parameter int MAX_VAL  = 31,
   parameter bit SATURATE = 1'b0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic             enab,
   input  logic             up,
   input  logic             clr_ovf,
   input  logic [WIDTH-1:0] cnt_in,
   output logic [WIDTH-1:0] cnt_out,
   output logic             wrap,
   output logic             ovf
);

   localparam logic [WIDTH-1:0] MAX_CNT = WIDTH'(MAX_VAL);
   localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

   logic [WIDTH-1:0] load_val;
   logic [WIDTH-1:0] step_val;
   logic             boundary;

   assign load_val = (cnt_in > MAX_CNT) ? MAX_CNT : cnt_in;

   // Boundary is detected by comparison so a MAX_VAL below 2**WIDTH-1 wraps correctly.
   always_comb begin
      // NOTE: every always_comb output gets a default first so no latch is inferred.
      step_val = cnt_out;
      boundary = 1'b0;
      if (up) begin
         if (cnt_out >= MAX_CNT) begin
            step_val = SATURATE ? MAX_CNT : '0;
            boundary = 1'b1;
         end else begin
            step_val = cnt_out + ONE;
         end
      end else begin
         if (cnt_out == '0) begin
            step_val = SATURATE ? '0 : MAX_CNT;
            boundary = 1'b1;
         end else begin
            step_val = cnt_out - ONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments only.
      if (!rst) begin
         cnt_out <= '0;
         wrap    <= 1'b0;
         ovf     <= 1'b0;
      end else if (load) begin
         cnt_out <= load_val;
         wrap    <= 1'b0;
         ovf     <= ovf & ~clr_ovf;
      end else if (enab) begin
         cnt_out <= step_val;
         wrap    <= boundary;
         ovf     <= boundary | (ovf & ~clr_ovf);
      end else begin
         wrap    <= 1'b0;
         ovf     <= ovf & ~clr_ovf;
      end
   end

endmodule
